// File: rtl/balance_pkg.sv
// Shared types, widths and saturation helper for the balance controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package balance_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int ERR_W     = 10;
  localparam int INTEG_W   = 18;
  localparam int SPD_W     = 12;
  localparam int DIFF_W    = 7;
  localparam int PID_W     = 16;
  localparam int SPD_MAX   = 2047;
  localparam int SPD_MIN   = -2048;
  localparam int SOFT_STEP = 16;

  // Clamp a signed value into the range of a width-bit two's complement number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

endpackage

// File: rtl/ptch_d_queue.sv
// Shift register of past pitch errors; oldest tap feeds the derivative term.
// Latency: push visible on oldest after DEPTH pushes.
// Backpressure: none; push is accepted every cycle it is asserted, clr wins over push.
module ptch_d_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                clr,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] oldest
);

  logic signed [W-1:0] q_q [DEPTH];

  // Shift new error in at the head; clearing zeroes the whole history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
    end else if (push) begin
      q_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) q_q[i] <= q_q[i-1];
    end
  end

  assign oldest = q_q[DEPTH-1];

endmodule

// File: rtl/balance_pid.sv
// Saturating PID balance controller with load-cell steering; BALANCE_SOFT_START_EN adds a ramping speed limit.
// Latency: speed outputs and spd_vld update 2 clocks after vld; fully pipelined at one vld per clock.
// Backpressure: none; every vld is consumed, rider_off discards in-flight work and zeroes outputs.
module balance_pid
  import balance_pkg::*;
#(
  // Kept as signed ints so the products with signed operands stay signed.
  parameter int P_COEFF       = 12,
  parameter int D_COEFF       = 7,
  parameter int D_QUEUE_DEPTH = 2,
  parameter int FAST_THRESH   = 1792
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld,
  input  logic signed [15:0]      ptch,
  input  logic signed [11:0]      ld_cell_diff,
  input  logic                    rider_off,
  input  logic                    en_steer,
  output logic signed [SPD_W-1:0] lft_spd,
  output logic signed [SPD_W-1:0] rght_spd,
  output logic                    spd_vld,
  output logic                    too_fast
);

  state_t                    state_q, state_d;
  logic                      clr, go;
  logic signed [ERR_W-1:0]   err_d, err_q, oldest;
  logic signed [INTEG_W-1:0] integ_sum, integ_d, integ_q;
  logic signed [DIFF_W-1:0]  diff_d, diff_q;
  logic                      s1_vld_q, s1_run_q;
  logic signed [31:0]        pid_d, steer_d, lft_c, rght_c;
  logic signed [SPD_W-1:0]   lft_d, rght_d, lft_q, rght_q;
  logic                      fast_d, too_fast_q, spd_vld_q;
`ifdef BALANCE_SOFT_START_EN
  logic [SPD_W-1:0]          limit_q;
  logic signed [31:0]        lim;
`endif

  // Idle whenever the rider is absent this cycle or the FSM has not yet entered RUN.
  assign clr = rider_off || (state_q == IDLE);
  assign go  = vld && !clr;

  // Rider presence FSM: next state follows rider_off directly.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (!rider_off) state_d = RUN;
    end else begin
      if (rider_off) state_d = IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  ptch_d_queue #(
    .DEPTH (D_QUEUE_DEPTH),
    .W     (ERR_W)
  ) u_d_queue (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (go),
    .clr    (clr),
    .din    (err_d),
    .oldest (oldest)
  );

  // Stage 1 math: saturated error, overflow-holding integrator, saturated derivative.
  always_comb begin
    err_d     = ERR_W'(sat_signed(32'(ptch), ERR_W));
    integ_sum = integ_q + INTEG_W'(err_d);
    integ_d   = integ_sum;
    if ((integ_q[INTEG_W-1] == err_d[ERR_W-1]) && (integ_sum[INTEG_W-1] != integ_q[INTEG_W-1]))
      integ_d = integ_q;
    diff_d    = DIFF_W'(sat_signed(32'(err_d) - 32'(oldest), DIFF_W));
  end

  // Stage 1 registers; s1_run_q marks samples that were taken while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= '0;
      integ_q  <= '0;
      diff_q   <= '0;
      s1_vld_q <= 1'b0;
      s1_run_q <= 1'b0;
    end else begin
      s1_vld_q <= vld;
      s1_run_q <= go;
      if (clr) begin
        err_q   <= '0;
        integ_q <= '0;
        diff_q  <= '0;
      end else if (go) begin
        err_q   <= err_d;
        integ_q <= integ_d;
        diff_q  <= diff_d;
      end
    end
  end

`ifdef BALANCE_SOFT_START_EN
  // Soft-start limit: restarts at zero when idle, ramps per accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit_q <= '0;
    end else if (clr) begin
      limit_q <= '0;
    end else if (go) begin
      if (int'(limit_q) > SPD_MAX - SOFT_STEP) limit_q <= SPD_W'(SPD_MAX);
      else                                     limit_q <= limit_q + SPD_W'(SOFT_STEP);
    end
  end
`endif

  // Stage 2 math: PID sum, steering split, clamp to the speed range.
  always_comb begin
    pid_d   = sat_signed(P_COEFF * 32'(err_q) + 32'(integ_q >>> 6) + D_COEFF * 32'(diff_q), PID_W);
    steer_d = en_steer ? 32'(ld_cell_diff >>> 3) : 32'sd0;
    lft_c   = sat_signed(pid_d - steer_d, SPD_W);
    rght_c  = sat_signed(pid_d + steer_d, SPD_W);
`ifdef BALANCE_SOFT_START_EN
    lim = 32'(limit_q);
    if (lft_c > lim)        lft_c = lim;
    else if (lft_c < -lim)  lft_c = -lim;
    if (rght_c > lim)       rght_c = lim;
    else if (rght_c < -lim) rght_c = -lim;
`endif
    fast_d = (lft_c > FAST_THRESH) || (lft_c < -FAST_THRESH) ||
             (rght_c > FAST_THRESH) || (rght_c < -FAST_THRESH);
    lft_d  = SPD_W'(lft_c);
    rght_d = SPD_W'(rght_c);
  end

  // Stage 2 registers: outputs zero while idle, update on each result, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q      <= '0;
      rght_q     <= '0;
      too_fast_q <= 1'b0;
      spd_vld_q  <= 1'b0;
    end else begin
      spd_vld_q <= s1_vld_q;
      if (clr || (s1_vld_q && !s1_run_q)) begin
        lft_q      <= '0;
        rght_q     <= '0;
        too_fast_q <= 1'b0;
      end else if (s1_vld_q) begin
        lft_q      <= lft_d;
        rght_q     <= rght_d;
        too_fast_q <= fast_d;
      end
    end
  end

  assign lft_spd  = lft_q;
  assign rght_spd = rght_q;
  assign too_fast = too_fast_q;
  assign spd_vld  = spd_vld_q;

endmodule

// File: tb/tb_balance_pid.sv
// Self-checking bench for balance_pid: directed literal checks plus randomized traffic against a behavioural model.
// Latency: model predicts outputs 2 clocks after each vld.
// Backpressure: none exercised beyond back-to-back vld and random rider_off drops.
module tb_balance_pid;

  localparam int DEPTH = 2;

  logic               clk = 1'b0;
  logic               rst_n, vld, rider_off, en_steer;
  logic signed [15:0] ptch;
  logic signed [11:0] ld_cell_diff;
  logic signed [11:0] lft_spd, rght_spd;
  logic               spd_vld, too_fast;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  balance_pid dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vld          (vld),
    .ptch         (ptch),
    .ld_cell_diff (ld_cell_diff),
    .rider_off    (rider_off),
    .en_steer     (en_steer),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .spd_vld      (spd_vld),
    .too_fast     (too_fast)
  );

  function automatic int sat(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int floordiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer arithmetic on whole samples.
  bit m_run = 1'b0;
  int m_integ = 0;
  int m_lim = 0;
  int m_hist[$];
  bit p_vld = 1'b0;
  bit p_run = 1'b0;
  int p_pid = 0;
  int exp_l = 0, exp_r = 0, exp_v = 0, exp_tf = 0;

  always @(posedge clk) begin
    bit clear;
    int err, d, l, r, steer;
    if (!rst_n) begin
      m_run = 1'b0; m_integ = 0; m_lim = 0; p_vld = 1'b0; p_run = 1'b0; p_pid = 0;
      m_hist = {};
      for (int i = 0; i < DEPTH; i++) m_hist.push_back(0);
      exp_l = 0; exp_r = 0; exp_v = 0; exp_tf = 0;
    end else begin
      clear = rider_off || !m_run;
      // result of the sample accepted on the previous edge
      if (clear) begin
        exp_l = 0; exp_r = 0; exp_tf = 0;
      end else if (p_vld) begin
        if (p_run) begin
          steer = en_steer ? floordiv(int'(ld_cell_diff), 8) : 0;
          l = sat(p_pid - steer, -2048, 2047);
          r = sat(p_pid + steer, -2048, 2047);
`ifdef BALANCE_SOFT_START_EN
          l = sat(l, -m_lim, m_lim);
          r = sat(r, -m_lim, m_lim);
`endif
          exp_l = l; exp_r = r;
          exp_tf = (iabs(l) > 1792 || iabs(r) > 1792) ? 1 : 0;
        end else begin
          exp_l = 0; exp_r = 0; exp_tf = 0;
        end
      end
      exp_v = p_vld ? 1 : 0;
      // accept the current sample
      p_vld = vld;
      p_run = vld && !clear;
      if (clear) begin
        m_integ = 0; m_lim = 0;
        for (int i = 0; i < DEPTH; i++) m_hist[i] = 0;
      end else if (vld) begin
        err = sat(int'(ptch), -512, 511);
        d = sat(err - m_hist[DEPTH-1], -64, 63);
        if (m_integ + err <= 131071 && m_integ + err >= -131072) m_integ = m_integ + err;
        p_pid = sat(12 * err + floordiv(m_integ, 64) + 7 * d, -32768, 32767);
        m_hist.push_front(err);
        void'(m_hist.pop_back());
        m_lim = (m_lim + 16 > 2047) ? 2047 : m_lim + 16;
      end
      m_run = !rider_off;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("model_lft_spd",  int'(lft_spd),  exp_l);
    chk("model_rght_spd", int'(rght_spd), exp_r);
    chk("model_spd_vld",  int'(spd_vld),  exp_v);
    chk("model_too_fast", int'(too_fast), exp_tf);
  end

  // One vld pulse, then wait until its result is visible.
  task automatic pulse(input logic signed [15:0] p);
    vld = 1'b1;
    ptch = p;
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int v;
    rst_n = 1'b0; vld = 1'b0; ptch = '0; ld_cell_diff = '0; rider_off = 1'b1; en_steer = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_lft", int'(lft_spd), 0);
    chk("rst_rght", int'(rght_spd), 0);
    chk("rst_spd_vld", int'(spd_vld), 0);
    chk("rst_too_fast", int'(too_fast), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_lft", int'(lft_spd), 0);
    chk("idle_spd_vld", int'(spd_vld), 0);

`ifndef BALANCE_SOFT_START_EN
    rider_off = 1'b0;
    repeat (2) @(negedge clk);
    pulse(16'sd16);
    chk("p16_1_vld", int'(spd_vld), 1);
    chk("p16_1_lft", int'(lft_spd), 304);
    chk("p16_1_rght", int'(rght_spd), 304);
    pulse(16'sd16);
    chk("p16_2_lft", int'(lft_spd), 304);
    pulse(16'sd16);
    chk("p16_3_lft", int'(lft_spd), 192);
    chk("p16_3_rght", int'(rght_spd), 192);
    pulse(16'h7FFF);
    chk("max_lft", int'(lft_spd), 2047);
    chk("max_rght", int'(rght_spd), 2047);
    chk("max_too_fast", int'(too_fast), 1);

    rider_off = 1'b1;
    @(negedge clk);
    chk("off_lft", int'(lft_spd), 0);
    chk("off_too_fast", int'(too_fast), 0);
    rider_off = 1'b0;
    repeat (2) @(negedge clk);
    en_steer = 1'b1; ld_cell_diff = 12'h100;
    pulse(16'sd0);
    chk("steer_lft", int'(lft_spd), -32);
    chk("steer_rght", int'(rght_spd), 32);
    en_steer = 1'b0;
    pulse(16'sd0);
    chk("nosteer_lft", int'(lft_spd), 0);
    chk("nosteer_rght", int'(rght_spd), 0);

    vld = 1'b1; ptch = 16'sd511;
    repeat (300) @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
    chk("sat_lft", int'(lft_spd), 2047);
    chk("sat_rght", int'(rght_spd), 2047);
    pulse(16'sd0);
    chk("hold_d1_lft", int'(lft_spd), 1596);
    pulse(16'sd0);
    chk("hold_d2_lft", int'(lft_spd), 1596);
    pulse(16'sd0);
    chk("hold_integ_lft", int'(lft_spd), 2044);
    chk("hold_integ_tf", int'(too_fast), 1);
    rider_off = 1'b1;
    @(negedge clk);
    chk("drop_lft", int'(lft_spd), 0);
    rider_off = 1'b0;
    repeat (2) @(negedge clk);
    pulse(16'sd0);
    chk("cleared_lft", int'(lft_spd), 0);
    chk("cleared_rght", int'(rght_spd), 0);
`else
    rider_off = 1'b0; en_steer = 1'b0; ld_cell_diff = '0;
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 130; k++) begin
      pulse(16'h7FFF);
      chk("soft_lft", int'(lft_spd), (16 * k > 2047) ? 2047 : 16 * k);
    end
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      vld = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: begin v = int'($urandom_range(0, 1200)); ptch = 16'(v - 600); end
        1: ptch = 16'($urandom);
        2: ptch = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
        default: begin v = int'($urandom_range(0, 100)); ptch = 16'(v - 50); end
      endcase
      if ($urandom_range(0, 7) == 0) begin
        ld_cell_diff = 12'($urandom);
        en_steer = ($urandom_range(0, 1) != 0);
      end
      if ($urandom_range(0, 59) == 0) rider_off = 1'b1;
      else if (rider_off && $urandom_range(0, 3) == 0) rider_off = 1'b0;
      @(negedge clk);
    end
    vld = 1'b0;
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
